green_bar_ctrl: RTL and testbench
=================================

Name: green_bar_ctrl

Overview:
- Sequences the green level-bar overlay drawer.
- Converts the fish-count value into a bar right edge T_x, plus a fixed bottom edge T_y.
- Animates the bar toward the target at a fixed pixel step per video frame.
- Updates the drawer's bounds only on frame boundaries, so a frame is never drawn with a half-updated bar.
- Drives the drawer's en input, including a blink when the bar is saturated.
- Sits between the counter logic and the drawer, in the pixel-clock domain.

Parameters:
- X1, 11'd341, bar left edge; T_x floor.
- X2, 11'd491, bar right limit; T_x ceiling.
- Y2, 10'd220, bar bottom edge; driven constant on T_y.
- CNT_W, 8, width of the count input.
- PX_PER_UNIT, 1, pixels of bar per count unit.
- STEP, 2, maximum pixels the bar moves per frame.
- BLINK_FRAMES, 16, frames per blink half-period when saturated.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- cnt_valid  in  1  one-cycle pulse; cnt is valid.
- cnt  in  CNT_W  new count value.
- clr  in  1  one-cycle pulse; forces target to 0.
- disp_on  in  1  overlay enable from the user switch.
- en_out  out  1  enable to the drawer.
- T_x  out  11  bar right edge to the drawer.
- T_y  out  10  bar bottom edge to the drawer.
- busy  out  1  bar is moving (cur != target).
- full  out  1  target saturated at the span limit.

Behaviour:
- Reset (reset==0 at a clk edge):
  - cur=0, target=0, state=IDLE.
  - T_x=X1, T_y=Y2, en_out=0, busy=0, full=0.
  - blink_cnt=0, blink_ph=1.
  - Reset overrides every other input in the same cycle.
- Span: SPAN = X2-X1 (150 at defaults).
- Target mapping: prod = cnt*PX_PER_UNIT, computed at width CNT_W+11.
  - If prod >= SPAN: target=SPAN and full=1.
  - Otherwise: target=prod and full=0.
  - Registered one cycle after cnt_valid.
- clr sets target=0 and full=0. clr has priority over a simultaneous cnt_valid.
- State is recomputed each cycle from cur vs target: IDLE (equal), RISE (cur<target), FALL (cur>target). busy = (state != IDLE).
- Step on frame_start only:
  - RISE: cur = min(cur+STEP, target).
  - FALL: cur = max(cur-STEP, target), computed without unsigned underflow.
  - IDLE: no change.
  - If frame_start and cnt_valid/clr arrive in the same cycle, the step uses the old target; the new target is latched in that cycle and takes effect at the next frame_start.
- Output timing:
  - T_x = X1+cur, registered in the same clock edge that updates cur. T_x therefore changes 1 cycle after frame_start and never between frames.
  - T_x is always within [X1, X2].
- Blink:
  - When full==1 and state==IDLE: blink_cnt increments on each frame_start. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_ph.
  - Otherwise blink_cnt=0 and blink_ph=1.
- Enable:
  - en_out = disp_on & (cur!=0) & blink_ph.
  - en_out is registered and updated only on frame_start, so it never changes mid-frame.
  - With disp_on=0, en_out is forced 0 at the next frame_start; cur continues to animate.
- Repeated cnt_valid within one frame: last value wins.

Decomposition:
- Shared package (overlay_pkg):
  - Bar geometry constants X1, X2, Y2 and SPAN; these are also used by the drawer.
  - State encoding IDLE/RISE/FALL as a 2-bit localparam set.
- One sub-module: bar_stepper. It holds cur and the saturating ±STEP update toward target. Blink logic, target mapping and output registers stay in the top.

Test Plan:
1. Reset, then cnt_valid with cnt=10, then 5 frame_start pulses.
   - T_x sequence: 343, 345, 347, 349, 351, then holds at 351.
   - busy drops after the 5th frame_start; en_out=1 after the 1st frame_start.
2. cnt=200 (prod 200 ≥ 150).
   - full=1; T_x saturates at 491 after 75 frames.
   - en_out then toggles every 16 frame_starts.
3. cnt=10 settled at T_x=351, then clr.
   - T_x falls 349, 347, … to 341.
   - en_out=0 at the frame_start where cur reaches 0.
4. frame_start and cnt_valid (cnt=3) in the same cycle while settled at cur=10.
   - That frame: no step (state IDLE).
   - Next frame_start: T_x=349.
   - Following frame_start: T_x=347; later 345, 344.
5. reset asserted mid-RISE (cur=20).
   - Next edge: T_x=341, en_out=0, busy=0, full=0.
   - Later frame_starts produce no movement until a new cnt_valid.
6. Toggle disp_on 1→0 mid-frame.
   - en_out stays 1 until the next frame_start, then goes 0.
   - T_x continues to animate.

Source files
------------

// File: rtl/overlay_pkg.sv
// Bar geometry and stepper direction codes shared by the bar controller and the overlay drawer.
package overlay_pkg;

  localparam logic [10:0] X1   = 11'd341;
  localparam logic [10:0] X2   = 11'd491;
  localparam logic [9:0]  Y2   = 10'd220;
  localparam logic [10:0] SPAN = X2 - X1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;

  function automatic logic [1:0] bar_dir(input logic [10:0] cur, input logic [10:0] target);
    if (cur < target) return ST_RISE;
    if (cur > target) return ST_FALL;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/bar_stepper.sv
// Holds the animated bar length and moves it toward the target by at most STEP pixels per step pulse.
module bar_stepper
  import overlay_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [1:0]  dir,
  input  logic [10:0] target,
  output logic [10:0] cur,
  output logic [10:0] cur_next
);

  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [10:0] cur_reg;

  // dir guarantees the sign of target-cur, so the distances below never wrap.
  always_comb begin
    cur_next = cur_reg;
    if (step) begin
      case (dir)
        ST_RISE: cur_next = ((target - cur_reg) > STEP_W) ? cur_reg + STEP_W : target;
        ST_FALL: cur_next = ((cur_reg - target) > STEP_W) ? cur_reg - STEP_W : target;
        default: cur_next = cur_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cur_reg <= '0;
    else        cur_reg <= cur_next;
  end

  assign cur = cur_reg;

endmodule

// File: rtl/green_bar_ctrl.sv
// Green level-bar sequencer: maps the fish count to a bar target, animates the drawer's
// right edge once per frame and gates the drawer enable, blinking while saturated.
module green_bar_ctrl
  import overlay_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int PX_PER_UNIT  = 1,
  parameter int STEP         = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             cnt_valid,
  input  logic [CNT_W-1:0] cnt,
  input  logic             clr,
  input  logic             disp_on,
  output logic             en_out,
  output logic [10:0]      T_x,
  output logic [9:0]       T_y,
  output logic             busy,
  output logic             full
);

  localparam int PW = CNT_W + 11;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] SPAN_P     = PW'(SPAN);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] prod;
  logic [10:0]   target_reg;
  logic          full_reg;
  logic [10:0]   cur;
  logic [10:0]   cur_next;
  logic [1:0]    state;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_ph_reg, blink_ph_next;
  logic [10:0]   tx_reg;
  logic          en_reg;

  assign prod = PW'(cnt) * PW'(PX_PER_UNIT);

  // Target latch: a step in the same cycle still sees the previous target.
  always_ff @(posedge clk) begin
    if (!reset) begin
      target_reg <= '0;
      full_reg   <= 1'b0;
    end else if (clr) begin
      target_reg <= '0;
      full_reg   <= 1'b0;
    end else if (cnt_valid) begin
      if (prod >= SPAN_P) begin
        target_reg <= SPAN;
        full_reg   <= 1'b1;
      end else begin
        target_reg <= prod[10:0];
        full_reg   <= 1'b0;
      end
    end
  end

  assign state = bar_dir(cur, target_reg);
  assign busy  = (state != ST_IDLE);

  bar_stepper #(
    .STEP(STEP)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .step     (frame_start),
    .dir      (state),
    .target   (target_reg),
    .cur      (cur),
    .cur_next (cur_next)
  );

  // Blink only counts frames while the bar is parked at the saturated limit.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    blink_ph_next  = blink_ph_reg;
    if (!(full_reg && (state == ST_IDLE))) begin
      blink_cnt_next = '0;
      blink_ph_next  = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        blink_ph_next  = ~blink_ph_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_reg <= '0;
      blink_ph_reg  <= 1'b1;
      tx_reg        <= X1;
      en_reg        <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      blink_ph_reg  <= blink_ph_next;
      if (frame_start) begin
        tx_reg <= X1 + cur_next;
        en_reg <= disp_on & (cur_next != 11'd0) & blink_ph_next;
      end
    end
  end

  assign T_x    = tx_reg;
  assign T_y    = Y2;
  assign en_out = en_reg;
  assign full   = full_reg;

endmodule

// File: tb/tb_green_bar_ctrl.sv
// Self-checking bench for green_bar_ctrl: directed scenarios plus randomized traffic
// compared against an integer reference model of the bar behaviour.
module tb_green_bar_ctrl;

  localparam int T_X1    = 341;
  localparam int T_Y2    = 220;
  localparam int T_SPAN  = 150;
  localparam int T_STEP  = 2;
  localparam int T_BLINK = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        cnt_valid = 1'b0;
  logic [7:0]  cnt = 8'd0;
  logic        clr = 1'b0;
  logic        disp_on = 1'b1;
  logic        en_out;
  logic [10:0] T_x;
  logic [9:0]  T_y;
  logic        busy;
  logic        full;

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers)
  int m_cur, m_target, m_frames;
  bit m_full, m_ph, m_en;

  green_bar_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .cnt_valid   (cnt_valid),
    .cnt         (cnt),
    .clr         (clr),
    .disp_on     (disp_on),
    .en_out      (en_out),
    .T_x         (T_x),
    .T_y         (T_y),
    .busy        (busy),
    .full        (full)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input bit fs, input bit cv, input int c, input bit cl);
    int p;
    if (!reset) begin
      m_cur = 0; m_target = 0; m_full = 0; m_frames = 0; m_ph = 1; m_en = 0;
      return;
    end
    if (m_full && m_cur == m_target) begin
      if (fs) begin
        m_frames++;
        if (m_frames == T_BLINK) begin m_frames = 0; m_ph = !m_ph; end
      end
    end else begin
      m_frames = 0; m_ph = 1;
    end
    if (fs) begin
      if (m_cur < m_target)      m_cur = (m_cur + T_STEP < m_target) ? m_cur + T_STEP : m_target;
      else if (m_cur > m_target) m_cur = (m_cur - T_STEP > m_target) ? m_cur - T_STEP : m_target;
      m_en = disp_on && (m_cur != 0) && m_ph;
    end
    if (cl) begin
      m_target = 0; m_full = 0;
    end else if (cv) begin
      p = c * 1;
      if (p >= T_SPAN) begin m_target = T_SPAN; m_full = 1; end
      else begin m_target = p; m_full = 0; end
    end
  endfunction

  task automatic tick(input bit fs, input bit cv, input int c, input bit cl);
    frame_start = fs; cnt_valid = cv; cnt = 8'(c); clr = cl;
    @(posedge clk);
    model_edge(fs, cv, c, cl);
    #1;
    frame_start = 1'b0; cnt_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(0, 0, 0, 0);
    reset = 1'b1;
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick(1, 1, 77, 0);
    checks++;
    if ({T_x, T_y, en_out, busy, full} !== {11'd341, 10'd220, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got T_x=%0d T_y=%0d en=%0b busy=%0b full=%0b want 341 220 0 0 0",
               T_x, T_y, en_out, busy, full);
    end
    reset = 1'b1;
    tick(0, 0, 0, 0);
    $display("test_reset done");
  endtask

  task automatic test_rise();
    do_reset();
    disp_on = 1'b1;
    tick(0, 1, 10, 0);
    $display("txn rise cnt=10");
    tick(0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(1, 0, 0, 0);
      checks++;
      if (T_x !== 11'(T_X1 + ((k < 5) ? 2 * k : 10))) begin
        errors++;
        $display("FAIL rise_tx[%0d]: got %0d want %0d", k, T_x, T_X1 + ((k < 5) ? 2 * k : 10));
      end
      checks++;
      if ({en_out, busy} !== {1'b1, (k < 5)}) begin
        errors++;
        $display("FAIL rise_en_busy[%0d]: got en=%0b busy=%0b want en=1 busy=%0b", k, en_out, busy, k < 5);
      end
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      checks++;
      if (T_x !== 11'(T_X1 + m_cur)) begin
        errors++;
        $display("FAIL rise_midframe[%0d]: got %0d want %0d", k, T_x, T_X1 + m_cur);
      end
    end
    $display("test_rise done");
  endtask

  task automatic test_saturate();
    do_reset();
    disp_on = 1'b1;
    tick(0, 1, 200, 0);
    $display("txn saturate cnt=200");
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL sat_full: got %0b want 1", full);
    end
    for (int k = 1; k <= 75; k++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      if (k == 74 || k == 75) begin
        checks++;
        if ({T_x, busy} !== {11'(T_X1 + 2 * k), (k == 74)}) begin
          errors++;
          $display("FAIL sat_edge[%0d]: got T_x=%0d busy=%0b want %0d %0b", k, T_x, busy, T_X1 + 2 * k, k == 74);
        end
      end
    end
    for (int j = 1; j <= 48; j++) begin
      tick(1, 0, 0, 0);
      checks++;
      if ({T_x, en_out, full} !== {11'd491, ((j / 16) % 2 == 0), 1'b1}) begin
        errors++;
        $display("FAIL sat_blink[%0d]: got T_x=%0d en=%0b full=%0b want 491 %0b 1", j, T_x, en_out, full, (j / 16) % 2 == 0);
      end
      tick(0, 0, 0, 0);
    end
    $display("test_saturate done");
  endtask

  task automatic test_clr();
    do_reset();
    disp_on = 1'b1;
    tick(0, 1, 10, 0);
    repeat (5) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    checks++;
    if (T_x !== 11'd351) begin
      errors++;
      $display("FAIL clr_settle: got %0d want 351", T_x);
    end
    tick(0, 0, 0, 1);
    $display("txn clr");
    for (int k = 1; k <= 6; k++) begin
      tick(1, 0, 0, 0);
      checks++;
      if ({T_x, en_out} !== {11'(351 - ((k < 5) ? 2 * k : 10)), (k < 5)}) begin
        errors++;
        $display("FAIL clr_fall[%0d]: got T_x=%0d en=%0b want %0d %0b", k, T_x, en_out, 351 - ((k < 5) ? 2 * k : 10), k < 5);
      end
      tick(0, 0, 0, 0);
    end
    $display("test_clr done");
  endtask

  task automatic test_same_cycle();
    int exp_tx[5] = '{349, 347, 345, 344, 344};
    do_reset();
    disp_on = 1'b1;
    tick(0, 1, 10, 0);
    repeat (5) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    tick(1, 1, 3, 0);
    $display("txn same_cycle cnt=3");
    checks++;
    if ({T_x, busy} !== {11'd351, 1'b1}) begin
      errors++;
      $display("FAIL same_hold: got T_x=%0d busy=%0b want 351 1", T_x, busy);
    end
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      checks++;
      if (T_x !== 11'(exp_tx[k])) begin
        errors++;
        $display("FAIL same_seq[%0d]: got %0d want %0d", k, T_x, exp_tx[k]);
      end
    end
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    disp_on = 1'b1;
    tick(0, 1, 40, 0);
    repeat (10) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    checks++;
    if (T_x !== 11'd361) begin
      errors++;
      $display("FAIL rmid_pre: got %0d want 361", T_x);
    end
    reset = 1'b0;
    tick(1, 1, 90, 0);
    reset = 1'b1;
    checks++;
    if ({T_x, en_out, busy, full} !== {11'd341, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_reset: got T_x=%0d en=%0b busy=%0b full=%0b want 341 0 0 0", T_x, en_out, busy, full);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      checks++;
      if ({T_x, busy, en_out} !== {11'd341, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rmid_still[%0d]: got T_x=%0d busy=%0b en=%0b want 341 0 0", k, T_x, busy, en_out);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_disp();
    do_reset();
    disp_on = 1'b1;
    tick(0, 1, 100, 0);
    repeat (5) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    disp_on = 1'b0;
    $display("txn disp_off");
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if ({en_out, T_x} !== {1'b1, 11'd351}) begin
      errors++;
      $display("FAIL disp_midframe: got en=%0b T_x=%0d want 1 351", en_out, T_x);
    end
    for (int k = 1; k <= 2; k++) begin
      tick(1, 0, 0, 0);
      checks++;
      if ({en_out, T_x} !== {1'b0, 11'(351 + 2 * k)}) begin
        errors++;
        $display("FAIL disp_off[%0d]: got en=%0b T_x=%0d want 0 %0d", k, en_out, T_x, 351 + 2 * k);
      end
      tick(0, 0, 0, 0);
    end
    disp_on = 1'b1;
    $display("test_disp done");
  endtask

  task automatic test_random();
    logic [13:0] exp_v, got_v;
    bit fs, cv, cl;
    int c;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      fs = ($urandom_range(0, 3) == 0);
      cv = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 47) == 0);
      c  = ($urandom_range(0, 3) == 0) ? $urandom_range(140, 255) : $urandom_range(0, 60);
      if ($urandom_range(0, 99) == 0) disp_on = ~disp_on;
      reset = ($urandom_range(0, 399) != 0);
      tick(fs, cv, c, cl);
      if (cv || cl) $display("txn rnd cyc=%0d cnt=%0d clr=%0b fs=%0b target=%0d", i, c, cl, fs, m_target);
      exp_v = {11'(T_X1 + m_cur), m_en, (m_cur != m_target), m_full};
      got_v = {T_x, en_out, busy, full};
      checks++;
      if (got_v !== exp_v || T_y !== 10'(T_Y2)) begin
        errors++;
        $display("FAIL rnd[%0d]: got T_x=%0d en=%0b busy=%0b full=%0b T_y=%0d want %0d %0b %0b %0b %0d",
                 i, T_x, en_out, busy, full, T_y, exp_v[13:3], exp_v[2], exp_v[1], exp_v[0], T_Y2);
      end
    end
    reset = 1'b1;
    disp_on = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_saturate();
    test_clr();
    test_same_cycle();
    test_reset_mid();
    test_disp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
